// File: rtl/alu_pkg.sv
// alu_pkg: op codes, MUL sequencer states and flag bit positions shared by alu_pipe
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_NAND, OP_SLL, OP_SRL, OP_ROL, OP_ROR,
    OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_MUL
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_e;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/shift_rot_unit.sv
// shift_rot_unit: combinational log2 barrel shifter; mode 0 SLL, 1 SRL, 2 ROL, 3 ROR
module shift_rot_unit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] amount,
  input  logic [1:0]               mode,
  output logic [WIDTH-1:0]         result
);
  localparam int SHAMT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] s [SHAMT_W+1];
  assign s[0] = data;
  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    localparam int K = 1 << i;
    assign s[i+1] = !amount[i] ? s[i] :
                    mode == 2'd0 ? s[i] << K :
                    mode == 2'd1 ? s[i] >> K :
                    mode == 2'd2 ? {s[i][WIDTH-1-K:0], s[i][WIDTH-1:WIDTH-K]} :
                                   {s[i][K-1:0], s[i][WIDTH-1:K]};
  end
  assign result = s[SHAMT_W];
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered execute-stage ALU with valid/ready handshake and iterative shift-add MUL
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);
  mul_state_e state, state_nx;
  logic [WIDTH-1:0] mcand, hi, lo, sh_res, res_nx;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH:0] add_s, sub_s, step;
  logic [3:0] flags_nx;
  logic ill_nx, accept, mul_start, done_load, out_load;
  assign in_ready  = (state == IDLE) & (~out_valid | out_ready) & ~rst;
  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (op == OP_MUL);
  assign done_load = (state == DONE) & (~out_valid | out_ready);
  assign out_load  = (accept & ~mul_start) | done_load;
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, b} + {1'b0, ~a} + {{WIDTH{1'b0}}, 1'b1};
  // {hi,lo} shifts right one multiplier bit per cycle; after WIDTH steps it holds the full product
  assign step = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  shift_rot_unit #(.WIDTH(WIDTH)) u_shift (
    .data(a), .amount(b[SHAMT_W-1:0]), .mode(op[1:0]), .result(sh_res)
  );
  always_comb begin
    res_nx = '0;
    flags_nx = '0;
    ill_nx = 1'b0;
    if (state == DONE) begin
      res_nx = lo;
      flags_nx[FLAG_V] = |hi;
    end else begin
      case (op)
        OP_ADD: begin
          {flags_nx[FLAG_C], res_nx} = add_s;
          flags_nx[FLAG_V] = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ add_s[WIDTH-1]);
        end
        OP_SUB: begin
          {flags_nx[FLAG_C], res_nx} = sub_s;
          flags_nx[FLAG_V] = (a[WIDTH-1] ^ b[WIDTH-1]) & (b[WIDTH-1] ^ sub_s[WIDTH-1]);
        end
        OP_XOR:  res_nx = a ^ b;
        OP_NAND: res_nx = ~(a & b);
        OP_SLL, OP_SRL, OP_ROL, OP_ROR: res_nx = sh_res;
        OP_SEQ:  res_nx = WIDTH'(a == b);
        OP_SLT:  res_nx = WIDTH'($signed(a) < $signed(b));
        OP_SLE:  res_nx = WIDTH'($signed(a) <= $signed(b));
        OP_SCO:  res_nx = WIDTH'(add_s[WIDTH]);
        OP_MUL:  res_nx = '0;
        default: ill_nx = 1'b1;
      endcase
    end
    flags_nx[FLAG_Z] = res_nx == '0;
    flags_nx[FLAG_N] = res_nx[WIDTH-1];
  end
  always_comb begin
    state_nx = mul_start ? MUL :
               (state == MUL && cnt == SHAMT_W'(WIDTH - 1)) ? DONE :
               done_load ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      illegal   <= 1'b0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nx;
      if (mul_start) begin
        mcand <= a;
        hi    <= '0;
        lo    <= b;
        cnt   <= '0;
      end else if (state == MUL) begin
        hi  <= step[WIDTH:1];
        lo  <= {step[0], lo[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
      end
      if (out_load) begin
        result  <= res_nx;
        flags   <= flags_nx;
        illegal <= ill_nx;
      end
      out_valid <= out_load | (out_valid & ~out_ready);
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench driving directed vectors into 16- and 32-bit alu_pipe instances
module tb_alu_pipe;
  import alu_pkg::*;
  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    logic        ill;
  } exp_t;
  logic clk = 0, rst = 1, out_ready = 1, v16 = 0, v32 = 0, sel = 0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic rdy16, rdy32, ov16, ov32, il16, il32;
  logic [15:0] res16;
  logic [31:0] res32;
  logic [3:0] fl16, fl32;
  logic rdy_s, ov_s;
  logic [31:0] res_s;
  logic [3:0] fl_s;
  logic il_s;
  exp_t q16[$], q32[$];
  exp_t e16, e32;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .op(op), .a(a[15:0]), .b(b[15:0]),
    .out_valid(ov16), .out_ready(out_ready), .result(res16), .flags(fl16), .illegal(il16)
  );
  alu_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .op(op), .a(a), .b(b),
    .out_valid(ov32), .out_ready(out_ready), .result(res32), .flags(fl32), .illegal(il32)
  );

  assign rdy_s = sel ? rdy32 : rdy16;
  assign ov_s  = sel ? ov32 : ov16;
  assign res_s = sel ? res32 : 32'(res16);
  assign fl_s  = sel ? fl32 : fl16;
  assign il_s  = sel ? il32 : il16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (w%0d): got %h expected %h at %0t", name, sel ? 32 : 16, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst && ov16 && out_ready) begin
    if (q16.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL out16_unexpected: got result %h with nothing expected", res16);
    end else begin
      e16 = q16.pop_front();
      check("res16", 32'(res16), e16.res);
      check("flags16", 32'(fl16), 32'(e16.fl));
      check("illegal16", 32'(il16), 32'(e16.ill));
    end
  end

  always @(negedge clk) if (!rst && ov32 && out_ready) begin
    if (q32.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL out32_unexpected: got result %h with nothing expected", res32);
    end else begin
      e32 = q32.pop_front();
      check("res32", res32, e32.res);
      check("flags32", 32'(fl32), 32'(e32.fl));
      check("illegal32", 32'(il32), 32'(e32.ill));
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y;
    if (sel) v32 = 1; else v16 = 1;
    #1;
    while (!rdy_s && n < 100) begin @(negedge clk); #1; n++; end
    if (n == 100) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1 v16 = 0; v32 = 0;
  endtask

  task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic [3:0] ef, input logic ei);
    exp_t e;
    e.res = er; e.fl = ef; e.ill = ei;
    if (sel) q32.push_back(e); else q16.push_back(e);
    issue(o, x, y);
  endtask

  task automatic run_set();
    int w = sel ? 32 : 16;
    int c0;
    logic [31:0] m = sel ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    logic [31:0] h = m >> 1;
    logic [31:0] msb = h + 1;
    logic [31:0] x = sel ? 32'h1234_5678 : 32'h1234;
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(rdy_s), 0);
    check("rst_out_valid", 32'(ov_s), 0);
    check("rst_result", res_s, 0);
    check("rst_flags", 32'(fl_s), 0);
    check("rst_illegal", 32'(il_s), 0);
    rst = 0;
    send(OP_ADD, h, 1, msb, 4'b0101, 0);
    check("add_latency", 32'(ov_s), 1);
    send(OP_SUB, 5, 3, m - 1, 4'b0100, 0);
    send(OP_SUB, 3, 5, 2, 4'b0010, 0);
    send(OP_ROL, msb | 1, sel ? 32'h21 : 32'h11, 3, 4'b0000, 0);
    send(OP_ROR, msb | 1, 4, sel ? 32'h1800_0000 : 32'h1800, 4'b0000, 0);
    send(OP_SRL, msb, sel ? 31 : 15, 1, 4'b0000, 0);
    send(OP_SLT, m, 1, 1, 4'b0000, 0);
    send(OP_SLT, 1, m, 0, 4'b1000, 0);
    send(OP_SLE, x, x, 1, 4'b0000, 0);
    send(OP_SCO, m, 1, 1, 4'b0000, 0);
    send(OP_XOR, sel ? 32'hF0F0_F0F0 : 32'hF0F0, sel ? 32'hFF00_FF00 : 32'hFF00,
         sel ? 32'h0FF0_0FF0 : 32'h0FF0, 4'b0000, 0);
    send(OP_NAND, m, m, 0, 4'b1000, 0);
    send(OP_SLL, 1, sel ? 31 : 15, msb, 4'b0100, 0);
    send(OP_SEQ, x, x + 1, 0, 4'b1000, 0);
    c0 = cyc;
    send(OP_ADD, 1, 2, 3, 4'b0000, 0);
    send(OP_ADD, 10, 20, 30, 4'b0000, 0);
    send(OP_ADD, m, m, m - 1, 4'b0110, 0);
    send(OP_ADD, msb, msb, 0, 4'b1011, 0);
    check("b2b_cycles", cyc - c0, 4);
    repeat (2) @(negedge clk);
    #1 out_ready = 0;
    send(OP_MUL, 32'h0123, 32'h0010, 32'h1230, 4'b0000, 0);
    a = '0; b = '0;
    for (int k = 1; k <= w; k++) begin
      @(posedge clk); #1;
      check("mul_busy", {30'd0, rdy_s, ov_s}, 0);
    end
    @(posedge clk); #1;
    check("mul_latency", 32'(ov_s), 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("mul_hold_result", res_s, 32'h1230);
      check("mul_hold_ready", 32'(rdy_s), 0);
    end
    out_ready = 1;
    send(OP_MUL, m, 2, m - 1, 4'b0101, 0);
    issue(OP_MUL, 3, 5);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 check("rdy_after_rst", 32'(rdy_s), 1);
    for (int k = 0; k < w + 4; k++) begin
      @(negedge clk);
      check("abort_no_out", 32'(ov_s), 0);
    end
    send(4'd14, 5, 6, 0, 4'b1000, 1);
    send(OP_ADD, 2, 2, 4, 4'b0000, 0);
  endtask

  initial begin
    int n = 0;
    sel = 0;
    run_set();
    sel = 1;
    run_set();
    while ((q16.size() != 0 || q32.size() != 0) && n < 200) begin @(negedge clk); n++; end
    if (n == 200) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d/%0d outputs pending expected 0", q16.size(), q32.size());
    end
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
